ddr2_mib_arbiter: RTL and testbench

DDR2_MIB_ARBITER -- requirements
Module: ddr2_mib_arbiter

---
 rtl/ddr2_mib_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_ddr2_mib_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/ddr2_mib_arbiter.sv
// Two-port round-robin arbiter in front of a DDR2 memory-controller
// command interface, with in-order read-return routing through a tag FIFO.
module ddr2_mib_arbiter #(
  parameter int C_MAX_OUTSTANDING = 8
) (
  input  logic         mc_mibclk,
  input  logic         mi_mcreset_n,
  input  logic         p0_valid,
  input  logic [0:35]  p0_addr,
  input  logic         p0_rnw,
  input  logic [0:15]  p0_be,
  input  logic [0:127] p0_wdata,
  output logic         p0_ready,
  output logic         p0_rvalid,
  output logic [0:127] p0_rdata,
  output logic         p0_rerr,
  input  logic         p1_valid,
  input  logic [0:35]  p1_addr,
  input  logic         p1_rnw,
  input  logic [0:15]  p1_be,
  input  logic [0:127] p1_wdata,
  output logic         p1_ready,
  output logic         p1_rvalid,
  output logic [0:127] p1_rdata,
  output logic         p1_rerr,
  output logic         mi_mcaddressvalid,
  output logic         mi_mcreadnotwrite,
  output logic         mi_mcwritedatavalid,
  output logic [0:35]  mi_mcaddress,
  output logic [0:15]  mi_mcbyteenable,
  output logic [0:127] mi_mcwritedata,
  output logic         mi_mcbankconflict,
  output logic         mi_mcrowconflict,
  input  logic         mc_miaddrreadytoaccept,
  input  logic         mc_mireaddatavalid,
  input  logic         mc_mireaddataerr,
  input  logic [0:127] mc_mireaddata,
  output logic         arb_err
);

  localparam int PW = $clog2(C_MAX_OUTSTANDING);
  localparam int CW = PW + 1;

  typedef enum logic {S_IDLE = 1'b0, S_ISSUE = 1'b1} state_t;

  state_t          state_q, state_d;
  logic            owner_q;
  logic            rr_q;
  logic            rnw_q;
  logic [0:35]     addr_q;
  logic [0:15]     be_q;
  logic [0:127]    wdata_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   wr_q, rd_q;
  logic            tag_q [C_MAX_OUTSTANDING];
  logic            err_q;
  logic            rv0_q, rv1_q, re0_q, re1_q;
  logic [0:127]    rd0_q, rd1_q;

  logic full, elig0, elig1, any_elig, grant1, accept, push, pop, head;

  // Eligibility, round-robin pick and FIFO handshakes.
  always_comb begin
    full     = (cnt_q == CW'(C_MAX_OUTSTANDING));
    elig0    = p0_valid & (~p0_rnw | ~full);
    elig1    = p1_valid & (~p1_rnw | ~full);
    any_elig = elig0 | elig1;
    grant1   = elig1 & (~elig0 | rr_q);
    accept   = (state_q == S_ISSUE) & mc_miaddrreadytoaccept;
    push     = accept & rnw_q;
    pop      = mc_mireaddatavalid & (cnt_q != '0);
    head     = tag_q[rd_q];
  end

  // State register.
  always_ff @(posedge mc_mibclk or negedge mi_mcreset_n) begin
    if (!mi_mcreset_n) state_q <= S_IDLE;
    else               state_q <= state_d;
  end

  // Next-state: grab a command when anyone is eligible, release on accept.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (any_elig) state_d = S_ISSUE;
      S_ISSUE: if (accept)   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: command qualifiers and the accept pulse to the owner.
  always_comb begin
    mi_mcaddressvalid   = (state_q == S_ISSUE);
    mi_mcwritedatavalid = (state_q == S_ISSUE) & ~rnw_q;
    p0_ready            = accept & ~owner_q;
    p1_ready            = accept & owner_q;
  end

  // Command capture from the winner and round-robin pointer update.
  always_ff @(posedge mc_mibclk or negedge mi_mcreset_n) begin
    if (!mi_mcreset_n) begin
      owner_q <= 1'b0;
      rr_q    <= 1'b0;
      rnw_q   <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
    end else begin
      if (state_q == S_IDLE && any_elig) begin
        owner_q <= grant1;
        rnw_q   <= grant1 ? p1_rnw   : p0_rnw;
        addr_q  <= grant1 ? p1_addr  : p0_addr;
        be_q    <= grant1 ? p1_be    : p0_be;
        wdata_q <= grant1 ? p1_wdata : p0_wdata;
      end
      if (accept) rr_q <= ~owner_q;
    end
  end

  // Outstanding-read count: push and pop together leave it unchanged.
  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Tag FIFO pointers, count and the sticky orphan-data flag.
  always_ff @(posedge mc_mibclk or negedge mi_mcreset_n) begin
    if (!mi_mcreset_n) begin
      cnt_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (push) wr_q <= wr_q + PW'(1);
      if (pop)  rd_q <= rd_q + PW'(1);
      if (mc_mireaddatavalid && cnt_q == '0) err_q <= 1'b1;
    end
  end

  // Tag storage; only entries between rd and wr are ever read.
  always_ff @(posedge mc_mibclk) begin
    if (push) tag_q[wr_q] <= owner_q;
  end

  // Read return: route the data one cycle later to the port at the FIFO head.
  always_ff @(posedge mc_mibclk or negedge mi_mcreset_n) begin
    if (!mi_mcreset_n) begin
      rv0_q <= 1'b0;
      rv1_q <= 1'b0;
      re0_q <= 1'b0;
      re1_q <= 1'b0;
      rd0_q <= '0;
      rd1_q <= '0;
    end else begin
      rv0_q <= pop & ~head;
      rv1_q <= pop & head;
      re0_q <= pop & ~head & mc_mireaddataerr;
      re1_q <= pop & head & mc_mireaddataerr;
      if (pop && !head) rd0_q <= mc_mireaddata;
      if (pop && head)  rd1_q <= mc_mireaddata;
    end
  end

  assign mi_mcreadnotwrite = rnw_q;
  assign mi_mcaddress      = addr_q;
  assign mi_mcbyteenable   = be_q;
  assign mi_mcwritedata    = wdata_q;
  assign mi_mcbankconflict = 1'b0;
  assign mi_mcrowconflict  = 1'b0;
  assign arb_err           = err_q;
  assign p0_rvalid         = rv0_q;
  assign p1_rvalid         = rv1_q;
  assign p0_rerr           = re0_q;
  assign p1_rerr           = re1_q;
  assign p0_rdata          = rd0_q;
  assign p1_rdata          = rd1_q;

endmodule

// File: tb/tb_ddr2_mib_arbiter.sv
// Randomized bench for ddr2_mib_arbiter against a transaction-level model
// (command slot, round-robin pointer, queue of outstanding read owners).
module tb_ddr2_mib_arbiter;
  localparam int MAXO = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         pv  [2];
  logic [0:35]  pa  [2];
  logic         prw [2];
  logic [0:15]  pbe [2];
  logic [0:127] pwd [2];
  logic         acc_in, rdv_in, rerr_in;
  logic [0:127] rdata_in;

  logic         p0_ready, p0_rvalid, p0_rerr, p1_ready, p1_rvalid, p1_rerr;
  logic [0:127] p0_rdata, p1_rdata;
  logic         mi_mcaddressvalid, mi_mcreadnotwrite, mi_mcwritedatavalid;
  logic [0:35]  mi_mcaddress;
  logic [0:15]  mi_mcbyteenable;
  logic [0:127] mi_mcwritedata;
  logic         mi_mcbankconflict, mi_mcrowconflict, arb_err;

  ddr2_mib_arbiter #(.C_MAX_OUTSTANDING(MAXO)) dut (
    .mc_mibclk(clk), .mi_mcreset_n(rst_n),
    .p0_valid(pv[0]), .p0_addr(pa[0]), .p0_rnw(prw[0]), .p0_be(pbe[0]), .p0_wdata(pwd[0]),
    .p0_ready(p0_ready), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_rerr(p0_rerr),
    .p1_valid(pv[1]), .p1_addr(pa[1]), .p1_rnw(prw[1]), .p1_be(pbe[1]), .p1_wdata(pwd[1]),
    .p1_ready(p1_ready), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_rerr(p1_rerr),
    .mi_mcaddressvalid(mi_mcaddressvalid), .mi_mcreadnotwrite(mi_mcreadnotwrite),
    .mi_mcwritedatavalid(mi_mcwritedatavalid), .mi_mcaddress(mi_mcaddress),
    .mi_mcbyteenable(mi_mcbyteenable), .mi_mcwritedata(mi_mcwritedata),
    .mi_mcbankconflict(mi_mcbankconflict), .mi_mcrowconflict(mi_mcrowconflict),
    .mc_miaddrreadytoaccept(acc_in), .mc_mireaddatavalid(rdv_in),
    .mc_mireaddataerr(rerr_in), .mc_mireaddata(rdata_in), .arb_err(arb_err)
  );

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got=%h expected=%h", tag, $time, got, exp);
    end
  endtask

  task automatic chk_zero(input string ph);
    chk({ph, " avalid"}, 128'(mi_mcaddressvalid), '0);
    chk({ph, " wdvalid"}, 128'(mi_mcwritedatavalid), '0);
    chk({ph, " rnw"}, 128'(mi_mcreadnotwrite), '0);
    chk({ph, " addr"}, 128'(mi_mcaddress), '0);
    chk({ph, " be"}, 128'(mi_mcbyteenable), '0);
    chk({ph, " wdata"}, 128'(mi_mcwritedata), '0);
    chk({ph, " ready"}, 128'({p0_ready, p1_ready}), '0);
    chk({ph, " rvalid"}, 128'({p0_rvalid, p1_rvalid}), '0);
    chk({ph, " rerr"}, 128'({p0_rerr, p1_rerr}), '0);
    chk({ph, " p0_rdata"}, 128'(p0_rdata), '0);
    chk({ph, " p1_rdata"}, 128'(p1_rdata), '0);
    chk({ph, " arb_err"}, 128'(arb_err), '0);
  endtask

  function automatic logic [0:127] r128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [0:35] r36();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[35:0];
  endfunction

  // Reference model state.
  bit           m_iss;
  int           m_own, m_rr;
  logic         m_rnw;
  logic [0:35]  m_addr;
  logic [0:15]  m_be;
  logic [0:127] m_wd;
  int           tagq[$];
  bit           m_err;
  int           m_rvp;
  logic [0:127] m_rvd;
  logic         m_rve;
  bit           gotrdy [2];

  initial begin
    int sz, w, nrvp, rdpct, retpct;
    bit e0, e1, acc, did_rst, allow_empty;
    logic [0:127] nrvd;
    logic nrve;

    rst_n = 1'b0;
    for (int n = 0; n < 2; n++) begin
      pv[n] = 1'b0; pa[n] = '0; prw[n] = 1'b0; pbe[n] = '0; pwd[n] = '0; gotrdy[n] = 1'b0;
    end
    acc_in = 1'b0; rdv_in = 1'b0; rerr_in = 1'b0; rdata_in = '0;
    m_iss = 0; m_own = 0; m_rr = 0; m_rnw = 0; m_addr = '0; m_be = '0; m_wd = '0;
    m_err = 0; m_rvp = -1; m_rvd = '0; m_rve = 0; did_rst = 0;

    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst_n = 1'b1;

    for (int cyc = 0; cyc < 1800; cyc++) begin
      @(posedge clk);
      #1;
      rdpct       = (cyc < 1200) ? 75 : 55;
      retpct      = (cyc < 600) ? 5 : (cyc < 1100) ? 35 : (!did_rst ? 0 : 30);
      allow_empty = did_rst;
      for (int n = 0; n < 2; n++) begin
        if (!pv[n] || gotrdy[n]) begin
          if ($urandom_range(0, 99) < 55) begin
            pv[n]  = 1'b1;
            prw[n] = ($urandom_range(0, 99) < rdpct);
            pa[n]  = r36();
            pbe[n] = 16'($urandom);
            pwd[n] = r128();
          end else begin
            pv[n] = 1'b0;
          end
        end
      end
      acc_in   = ($urandom_range(0, 99) < 60);
      rdv_in   = (allow_empty || tagq.size() > 0) && ($urandom_range(0, 99) < retpct);
      rerr_in  = ($urandom_range(0, 3) == 0);
      rdata_in = r128();

      if (!did_rst && cyc >= 1200 && ((m_iss && tagq.size() >= 3) || cyc == 1400)) begin
        did_rst = 1;
        rst_n = 1'b0;
        #1;
        chk_zero("midrst");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_iss = 0; m_rr = 0; m_err = 0; m_rvp = -1;
        tagq.delete();
      end
      #1;

      // Compare DUT against the model for this cycle.
      acc = m_iss && acc_in;
      chk("avalid", 128'(mi_mcaddressvalid), 128'(m_iss));
      chk("wdvalid", 128'(mi_mcwritedatavalid), 128'(m_iss && !m_rnw));
      if (m_iss) begin
        chk("addr", 128'(mi_mcaddress), 128'(m_addr));
        chk("rnw", 128'(mi_mcreadnotwrite), 128'(m_rnw));
        chk("be", 128'(mi_mcbyteenable), 128'(m_be));
        if (!m_rnw) chk("wdata", 128'(mi_mcwritedata), 128'(m_wd));
      end
      chk("p0_ready", 128'(p0_ready), 128'(acc && m_own == 0));
      chk("p1_ready", 128'(p1_ready), 128'(acc && m_own == 1));
      chk("p0_rvalid", 128'(p0_rvalid), 128'(m_rvp == 0));
      chk("p1_rvalid", 128'(p1_rvalid), 128'(m_rvp == 1));
      chk("p0_rerr", 128'(p0_rerr), 128'(m_rvp == 0 && m_rve));
      chk("p1_rerr", 128'(p1_rerr), 128'(m_rvp == 1 && m_rve));
      if (m_rvp == 0) chk("p0_rdata", 128'(p0_rdata), 128'(m_rvd));
      if (m_rvp == 1) chk("p1_rdata", 128'(p1_rdata), 128'(m_rvd));
      chk("arb_err", 128'(arb_err), 128'(m_err));
      chk("conflict", 128'({mi_mcbankconflict, mi_mcrowconflict}), '0);

      // Advance the model across the coming clock edge.
      sz = tagq.size();
      nrvp = -1; nrvd = '0; nrve = 1'b0;
      if (rdv_in) begin
        if (sz > 0) begin
          nrvp = tagq.pop_front();
          nrvd = rdata_in;
          nrve = rerr_in;
        end else begin
          m_err = 1;
        end
      end
      gotrdy[0] = 0;
      gotrdy[1] = 0;
      if (acc) begin
        if (m_rnw) tagq.push_back(m_own);
        m_rr = 1 - m_own;
        m_iss = 0;
        gotrdy[m_own] = 1;
      end else if (!m_iss) begin
        e0 = pv[0] && (!prw[0] || sz < MAXO);
        e1 = pv[1] && (!prw[1] || sz < MAXO);
        if (e0 || e1) begin
          w = (e0 && e1) ? m_rr : (e1 ? 1 : 0);
          m_own  = w;
          m_rnw  = prw[w];
          m_addr = pa[w];
          m_be   = pbe[w];
          m_wd   = pwd[w];
          m_iss  = 1;
        end
      end
      m_rvp = nrvp;
      m_rvd = nrvd;
      m_rve = nrve;
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
